delay_pipe_arbiter: RTL

DELAY_PIPE_ARBITER -- requirements
Module: delay_pipe_arbiter

---
 rtl/delay_pipe_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/delay_pipe_arbiter.sv
// delay_pipe_arbiter
//   Round-robin arbiter that feeds a fixed-latency pipeline of Depth stages.
//   A granted request enters stage 0. Each stage moves one step per cycle
//   and reaches the output Depth cycles later. Empty stages (bubbles) are
//   never removed. If the output stage is valid and downstream does not
//   accept it, the whole pipe holds and no new grant is given.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active high
//   req_valid_i  [NumReq]            per-requester request valid
//   req_data_i   [NumReq*DataWidth]  per-requester payload, slot i at i*DataWidth
//   req_ready_o  [NumReq]            per-requester grant, one-hot or zero
//   rsp_valid_o                      output stage holds a valid entry
//   rsp_id_o     [IdWidth]           requester index of the output entry
//   rsp_data_o   [DataWidth]         payload of the output entry
//   rsp_ready_i                      downstream accepts the output entry
//   inflight_o   [CntWidth]          number of valid entries in the pipe
module delay_pipe_arbiter #(
  parameter int NumReq    = 2,
  parameter int DataWidth = 8,
  parameter int Depth     = 3,
  localparam int IdWidth  = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int CntWidth = $clog2(Depth + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic                        rsp_valid_o,
  output logic [IdWidth-1:0]          rsp_id_o,
  output logic [DataWidth-1:0]        rsp_data_o,
  input  logic                        rsp_ready_i,
  output logic [CntWidth-1:0]         inflight_o
);

  logic [Depth-1:0]                valid_q;
  logic [Depth-1:0][IdWidth-1:0]   id_q;
  logic [Depth-1:0][DataWidth-1:0] data_q;
  logic [IdWidth-1:0]              ptr_q;
  logic [CntWidth-1:0]             inflight_q;

  logic                 stall;
  logic                 xfer_in;
  logic                 xfer_out;
  logic [NumReq-1:0]    grant;
  logic [IdWidth-1:0]   grant_id;
  logic [DataWidth-1:0] grant_data;
  logic                 found;
  int                   idx;

  assign stall    = valid_q[Depth-1] & ~rsp_ready_i;
  assign xfer_in  = |grant;
  assign xfer_out = valid_q[Depth-1] & rsp_ready_i;

  // Search from ptr upward with wrap-around; first valid requester wins.
  // The grant is forced to zero during a stall and while reset is held.
  always_comb begin
    grant      = '0;
    grant_id   = '0;
    grant_data = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < NumReq; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!found && req_valid_i[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IdWidth'(idx);
        grant_data = req_data_i[idx*DataWidth +: DataWidth];
      end
    end
    if (stall || rst_i) grant = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      id_q       <= '0;
      data_q     <= '0;
      ptr_q      <= '0;
      inflight_q <= '0;
    end else begin
      if (!stall) begin
        for (int k = Depth - 1; k > 0; k--) begin
          valid_q[k] <= valid_q[k-1];
          id_q[k]    <= id_q[k-1];
          data_q[k]  <= data_q[k-1];
        end
        valid_q[0] <= xfer_in;
        id_q[0]    <= grant_id;
        data_q[0]  <= grant_data;
      end
      if (xfer_in) begin
        ptr_q <= (grant_id == IdWidth'(NumReq - 1)) ? '0 : grant_id + IdWidth'(1);
      end
      // Tracks the popcount of valid_q without an adder tree.
      if (xfer_in && !xfer_out) begin
        inflight_q <= inflight_q + CntWidth'(1);
      end else if (!xfer_in && xfer_out) begin
        inflight_q <= inflight_q - CntWidth'(1);
      end
    end
  end

  assign req_ready_o = grant;
  assign rsp_valid_o = valid_q[Depth-1];
  assign rsp_id_o    = id_q[Depth-1];
  assign rsp_data_o  = data_q[Depth-1];
  assign inflight_o  = inflight_q;

endmodule
